// File: rtl/beam_sat_accumulator_if.sv
// Streaming bus for the beam accumulator: sample beats in, frame sums and overflow flags out.
// master = upstream/downstream environment, slave = the accumulator.
interface beam_sat_accumulator_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [CHANNELS-1:0]       out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/beam_sat_accumulator.sv
// Per-lane signed frame accumulator with step-wise overflow detection, optional clamping,
// and a valid/ready frame handoff (ACC collects LEN beats, DUMP holds the result).
module beam_sat_accumulator #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int LEN      = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    beam_sat_accumulator_if.slave bus
);
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LEN - 1);
    localparam logic [WIDTH-1:0] SAT_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DUMP = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_next;
    logic [WIDTH-1:0]    r_acc       [CHANNELS];
    logic [WIDTH-1:0]    w_acc_next  [CHANNELS];
    logic [WIDTH-1:0]    w_step_res  [CHANNELS];
    logic [CHANNELS-1:0] w_step_ovf;
    logic [CHANNELS-1:0] r_ovf;
    logic [CHANNELS-1:0] w_ovf_next;
    logic                w_accept;

    // Overflow is judged on every add, so a clamped lane that walks back keeps its flag.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        logic [WIDTH-1:0] w_b;
        logic [WIDTH-1:0] w_sum;

        assign w_b   = bus.in_data[k*WIDTH +: WIDTH];
        assign w_sum = r_acc[k] + w_b;

        assign w_step_ovf[k] = (r_acc[k][WIDTH-1] == w_b[WIDTH-1]) &&
                               (w_sum[WIDTH-1] != r_acc[k][WIDTH-1]);

        assign w_step_res[k] = (SATURATE && w_step_ovf[k])
                             ? (r_acc[k][WIDTH-1] ? SAT_MIN : SAT_MAX)
                             : w_sum;

        assign bus.out_data[k*WIDTH +: WIDTH] = r_acc[k];
    end

    // Ready is a function of state only, so no ready-to-ready path exists.
    assign bus.in_ready  = (r_state == ST_ACC) && !reset;
    assign bus.out_valid = (r_state == ST_DUMP);
    assign bus.out_ovf   = r_ovf;
    assign w_accept      = (r_state == ST_ACC) && bus.in_valid;

    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_ovf_next   = r_ovf;
        for (int k = 0; k < CHANNELS; k++) begin
            w_acc_next[k] = r_acc[k];
        end

        if (clear) begin
            w_state_next = ST_ACC;
            w_count_next = '0;
            w_ovf_next   = '0;
            for (int k = 0; k < CHANNELS; k++) begin
                w_acc_next[k] = '0;
            end
        end else begin
            unique case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        w_ovf_next = r_ovf | w_step_ovf;
                        for (int k = 0; k < CHANNELS; k++) begin
                            w_acc_next[k] = w_step_res[k];
                        end
                        if (r_count == LAST_BEAT) begin
                            w_count_next = '0;
                            w_state_next = ST_DUMP;
                        end else begin
                            w_count_next = r_count + 1'b1;
                        end
                    end
                end
                ST_DUMP: begin
                    if (bus.out_ready) begin
                        w_state_next = ST_ACC;
                        w_ovf_next   = '0;
                        for (int k = 0; k < CHANNELS; k++) begin
                            w_acc_next[k] = '0;
                        end
                    end
                end
                default: w_state_next = ST_ACC;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_ACC;
            r_count <= '0;
            r_ovf   <= '0;
            // NOTE: the accumulator array is a flop bank, not RAM, so resetting it is cheap and required.
            for (int k = 0; k < CHANNELS; k++) begin
                r_acc[k] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_ovf   <= w_ovf_next;
            for (int k = 0; k < CHANNELS; k++) begin
                r_acc[k] <= w_acc_next[k];
            end
        end
    end
endmodule

// File: tb/tb_beam_sat_accumulator.sv
// Directed bench: a saturating and a wrapping accumulator (WIDTH=16, CHANNELS=2, LEN=4)
// driven through frames, overflow cases, backpressure, clear and reset.
module tb_beam_sat_accumulator;
    logic clk;
    logic reset;
    logic clear;
    int   total;
    int   bad;

    beam_sat_accumulator_if #(.WIDTH(16), .CHANNELS(2)) if_s ();
    beam_sat_accumulator_if #(.WIDTH(16), .CHANNELS(2)) if_w ();

    beam_sat_accumulator #(.WIDTH(16), .CHANNELS(2), .LEN(4), .SATURATE(1'b1)) dut_s (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (if_s)
    );

    beam_sat_accumulator #(.WIDTH(16), .CHANNELS(2), .LEN(4), .SATURATE(1'b0)) dut_w (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (if_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One accepted beat on the saturating instance: lane0 = a, lane1 = b.
    task automatic beat_s(input logic [15:0] a, input logic [15:0] b);
        if_s.in_valid = 1'b1;
        if_s.in_data  = {b, a};
        tick();
        if_s.in_valid = 1'b0;
    endtask

    task automatic beat_w(input logic [15:0] a, input logic [15:0] b);
        if_w.in_valid = 1'b1;
        if_w.in_data  = {b, a};
        tick();
        if_w.in_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        clear = 1'b0;
        if_s.in_valid  = 1'b0;
        if_s.in_data   = '0;
        if_s.out_ready = 1'b1;
        if_w.in_valid  = 1'b0;
        if_w.in_data   = '0;
        if_w.out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready_low", if_s.in_ready, 1'b0);
        chk("rst_out_valid", if_s.out_valid, 1'b0);
        chk("rst_out_data", if_s.out_data, 32'h0);
        chk("rst_out_ovf", if_s.out_ovf, 2'b00);
        reset = 1'b0;
        #1;
        chk("rst_in_ready_high", if_s.in_ready, 1'b1);

        // Basic frame: lane0 1..4, lane1 -1 x4
        beat_s(16'd1, 16'hFFFF);
        beat_s(16'd2, 16'hFFFF);
        beat_s(16'd3, 16'hFFFF);
        chk("basic_no_early_valid", if_s.out_valid, 1'b0);
        beat_s(16'd4, 16'hFFFF);
        chk("basic_out_valid", if_s.out_valid, 1'b1);
        chk("basic_in_ready_dump", if_s.in_ready, 1'b0);
        chk("basic_out_data", if_s.out_data, 32'hFFFC_000A);
        chk("basic_out_ovf", if_s.out_ovf, 2'b00);
        tick();
        chk("basic_valid_one_cycle", if_s.out_valid, 1'b0);
        chk("basic_acc_cleared", if_s.out_data, 32'h0);
        chk("basic_in_ready_back", if_s.in_ready, 1'b1);

        // Positive saturation
        for (int i = 0; i < 4; i++) beat_s(16'h7000, 16'h0000);
        chk("possat_valid", if_s.out_valid, 1'b1);
        chk("possat_data", if_s.out_data, 32'h0000_7FFF);
        chk("possat_ovf", if_s.out_ovf, 2'b01);
        tick();

        // Negative saturation, then walk back into range
        beat_s(16'h8000, 16'h0000);
        beat_s(16'h8000, 16'h0000);
        beat_s(16'h0005, 16'h0000);
        beat_s(16'h0001, 16'h0000);
        chk("negsat_valid", if_s.out_valid, 1'b1);
        chk("negsat_data", if_s.out_data, 32'h0000_8006);
        chk("negsat_ovf_sticky", if_s.out_ovf, 2'b01);
        tick();

        // Backpressure: DUMP held for 5 cycles with beats offered
        if_s.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat_s(16'd1, 16'd2);
        if_s.in_valid = 1'b1;
        if_s.in_data  = {16'd100, 16'd100};
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", if_s.in_ready, 1'b0);
            chk("bp_out_valid", if_s.out_valid, 1'b1);
            chk("bp_out_data", if_s.out_data, 32'h0008_0004);
            chk("bp_out_ovf", if_s.out_ovf, 2'b00);
            tick();
        end
        if_s.in_valid  = 1'b0;
        if_s.out_ready = 1'b1;
        tick();
        chk("bp_transfer_once", if_s.out_valid, 1'b0);
        chk("bp_no_beats_taken", if_s.out_data, 32'h0);
        for (int i = 0; i < 3; i++) beat_s(16'd1, 16'd0);
        chk("bp_fresh_not_early", if_s.out_valid, 1'b0);
        beat_s(16'd1, 16'd0);
        chk("bp_fresh_valid", if_s.out_valid, 1'b1);
        chk("bp_fresh_data", if_s.out_data, 32'h0000_0004);
        tick();

        // clear after 2 beats, with a beat offered in the same cycle
        beat_s(16'd10, 16'd20);
        beat_s(16'd10, 16'd20);
        clear = 1'b1;
        beat_s(16'd50, 16'd50);
        clear = 1'b0;
        chk("clr_out_valid", if_s.out_valid, 1'b0);
        beat_s(16'd1, 16'd2);
        beat_s(16'd3, 16'd4);
        beat_s(16'd5, 16'd6);
        chk("clr_needs_4_beats", if_s.out_valid, 1'b0);
        beat_s(16'd7, 16'd8);
        chk("clr_frame_valid", if_s.out_valid, 1'b1);
        chk("clr_frame_data", if_s.out_data, 32'h0014_0010);
        tick();

        // clear discards a pending DUMP frame
        if_s.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat_s(16'h7000, 16'd1);
        chk("clrdump_valid_before", if_s.out_valid, 1'b1);
        chk("clrdump_ovf_before", if_s.out_ovf, 2'b01);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clrdump_valid", if_s.out_valid, 1'b0);
        chk("clrdump_data", if_s.out_data, 32'h0);
        chk("clrdump_ovf", if_s.out_ovf, 2'b00);
        chk("clrdump_in_ready", if_s.in_ready, 1'b1);

        // Reset asserted in DUMP
        beat_s(16'h7000, 16'h8000);
        beat_s(16'h7000, 16'h8000);
        beat_s(16'h7000, 16'h0000);
        beat_s(16'h7000, 16'h0000);
        chk("rstdump_valid_before", if_s.out_valid, 1'b1);
        chk("rstdump_data_before", if_s.out_data, 32'h8000_7FFF);
        chk("rstdump_ovf_before", if_s.out_ovf, 2'b11);
        reset = 1'b1;
        tick();
        chk("rstdump_valid", if_s.out_valid, 1'b0);
        chk("rstdump_data", if_s.out_data, 32'h0);
        chk("rstdump_ovf", if_s.out_ovf, 2'b00);
        chk("rstdump_in_ready_low", if_s.in_ready, 1'b0);
        reset = 1'b0;
        if_s.out_ready = 1'b1;
        #1;
        chk("rstdump_in_ready_high", if_s.in_ready, 1'b1);

        // Wrap mode on the non-saturating instance
        beat_w(16'h7FFF, 16'h0000);
        beat_w(16'h0001, 16'h0000);
        beat_w(16'h0000, 16'h0000);
        beat_w(16'h0000, 16'h0000);
        chk("wrap_valid", if_w.out_valid, 1'b1);
        chk("wrap_data", if_w.out_data, 32'h0000_8000);
        chk("wrap_ovf", if_w.out_ovf, 2'b01);
        tick();
        chk("wrap_handoff", if_w.out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
